gppcu_instr_queue: RTL and testbench
====================================

GPPCU_INSTR_QUEUE -- requirements
Module: gppcu_instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of two, >= 4).
REQ-002 SHALL have parameter AW, default 4, pointer width; DEPTH equals 2**AW.
REQ-003 SHALL have parameter SYNC_OP, default 4'hF, value of instruction bits [31:28] that marks a SYNC instruction.
REQ-004 SHALL have port iACLK, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port iARESETn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port iINSTR, input, 32: instruction word from the host.
REQ-007 SHALL have port iINSTR_VALID, input, 1: host presents iINSTR.
REQ-008 SHALL have port oINSTR_READY, output, 1: queue accepts a word this cycle.
REQ-009 SHALL have port oISSUE_INSTR, output, 32: head instruction to the core.
REQ-010 SHALL have port oISSUE_VALID, output, 1: oISSUE_INSTR is valid for issue.
REQ-011 SHALL have port iISSUE_READY, input, 1: core accepts oISSUE_INSTR.
REQ-012 SHALL have port iCORE_IDLE, input, 1: all core threads have retired.
REQ-013 SHALL have port iFLUSH, input, 1: synchronous discard of all queued words.
REQ-014 SHALL have port oCOUNT, output, AW+1: current occupancy, 0..DEPTH.
REQ-015 SHALL have port oSYNC_WAIT, output, 1: high while the head is a SYNC waiting on iCORE_IDLE.

Function
REQ-016 SHALL store words in a DEPTH-entry circular buffer with AW-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-017 SHALL drive oINSTR_READY = (oCOUNT != DEPTH), combinational from registered state only; it SHALL NOT depend on iISSUE_READY.
REQ-018 SHALL perform a push when iINSTR_VALID & oINSTR_READY: write iINSTR at the write pointer and increment it.
REQ-019 SHALL make a pushed word visible on oISSUE_INSTR no earlier than, and exactly at, the cycle after the push when the queue was empty (one-cycle latency).
REQ-020 SHALL drive oISSUE_INSTR = buffer[read pointer] at all times; the value is don't-care while oISSUE_VALID is low.
REQ-021 SHALL implement a two-state FSM, RUN and SYNC_WAIT, updated each cycle from the head word.
REQ-022 In RUN, with a non-empty queue and head[31:28] != SYNC_OP, SHALL assert oISSUE_VALID; a pop occurs when oISSUE_VALID & iISSUE_READY.
REQ-023 In RUN, with a non-empty queue and head[31:28] == SYNC_OP, SHALL deassert oISSUE_VALID and move to SYNC_WAIT on the next edge.
REQ-024 In SYNC_WAIT, SHALL hold oISSUE_VALID low and oSYNC_WAIT high.
REQ-025 In SYNC_WAIT, when iCORE_IDLE is high, SHALL pop the SYNC word internally without issuing it and return to RUN on the same edge.
REQ-026 SYNC words SHALL never appear with oISSUE_VALID high.
REQ-027 On a simultaneous push and pop, SHALL leave oCOUNT unchanged and advance both pointers.
REQ-028 When full, SHALL block a push even if a pop occurs in the same cycle.
REQ-029 When empty, SHALL keep oISSUE_VALID low; a push in that cycle SHALL NOT issue in the same cycle.
REQ-030 SHALL keep oISSUE_INSTR and oISSUE_VALID stable while oISSUE_VALID & !iISSUE_READY, except under iFLUSH.
REQ-031 iFLUSH SHALL have priority over push and pop: on the next edge pointers and count go to 0 and the FSM goes to RUN; a push in the flush cycle is discarded.
REQ-032 oCOUNT SHALL be a registered occupancy counter and SHALL never exceed DEPTH or go below 0.

Reset
REQ-033 While iARESETn is low, SHALL asynchronously clear pointers and oCOUNT to 0 and set the FSM to RUN; thus oISSUE_VALID=0, oSYNC_WAIT=0, oINSTR_READY=1.
REQ-034 Buffer contents SHALL NOT require reset.
REQ-035 Reset asserted mid-operation SHALL discard all queued words, including a SYNC in wait.
REQ-036 Pushes and pops SHALL resume on the first rising edge after iARESETn deasserts.

Verification
REQ-037 Push 0x00000001..0x00000010 (16 words) with iISSUE_READY=0 -> oCOUNT=16, oINSTR_READY=0; a 17th push is not accepted.
REQ-038 With the queue full, raise iISSUE_READY -> words issue in order 0x00000001..0x00000010, one per cycle, and oCOUNT returns to 0.
REQ-039 Push 0x12345678, 0xF0000000, 0x0000ABCD with iCORE_IDLE=0 -> 0x12345678 issues, then oSYNC_WAIT=1 and oISSUE_VALID=0; raise iCORE_IDLE -> the next issued word is 0x0000ABCD and 0xF0000000 is never issued.
REQ-040 At oCOUNT=5, push and pop every cycle for 20 cycles -> oCOUNT stays 5, pointers wrap, and the issued order matches the pushed order.
REQ-041 At oCOUNT=7, assert iFLUSH with a concurrent push -> next cycle oCOUNT=0 and oISSUE_VALID=0.
REQ-042 Assert iARESETn low during SYNC_WAIT, asynchronously to the clock -> oSYNC_WAIT=0, oCOUNT=0, oINSTR_READY=1 immediately.

Source files
------------

// File: rtl/gppcu_instr_queue.sv
// Instruction queue between host and core: circular FIFO whose head is held back while it is a
// SYNC word, until the core reports idle, at which point the SYNC is dropped without issue.
module gppcu_instr_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter logic [3:0]  SYNC_OP = 4'hF
) (
  input  logic          iACLK,
  input  logic          iARESETn,
  input  logic [31:0]   iINSTR,
  input  logic          iINSTR_VALID,
  output logic          oINSTR_READY,
  output logic [31:0]   oISSUE_INSTR,
  output logic          oISSUE_VALID,
  input  logic          iISSUE_READY,
  input  logic          iCORE_IDLE,
  input  logic          iFLUSH,
  output logic [AW:0]   oCOUNT,
  output logic          oSYNC_WAIT
);

  localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CntOne    = 1;
  localparam logic [AW-1:0] PtrOne    = 1;

  typedef enum logic [0:0] {StRun, StSyncWait} state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          empty, full, head_sync;
  logic          push, pop, issue_valid, sync_wait;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FullCount);
  assign head_sync = (mem_q[rptr_q][31:28] == SYNC_OP);
  // Flush wins over any push in the same cycle.
  assign push      = iINSTR_VALID & ~full & ~iFLUSH;

  always_comb begin
    state_d     = state_q;
    issue_valid = 1'b0;
    sync_wait   = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!empty) begin
          if (head_sync) begin
            state_d = StSyncWait;
          end else begin
            issue_valid = 1'b1;
            pop         = iISSUE_READY;
          end
        end
      end
      StSyncWait: begin
        sync_wait = 1'b1;
        // Retire the SYNC internally once the core has drained.
        if (iCORE_IDLE) begin
          pop     = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (iFLUSH) state_d = StRun;
  end

  always_ff @(posedge iACLK or negedge iARESETn) begin
    if (!iARESETn) begin
      state_q <= StRun;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (iFLUSH) begin
      state_q <= StRun;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      if (push && !pop)      count_q <= count_q + CntOne;
      else if (pop && !push) count_q <= count_q - CntOne;
    end
  end

  always_ff @(posedge iACLK) begin
    if (push) mem_q[wptr_q] <= iINSTR;
  end

  assign oINSTR_READY = ~full;
  assign oISSUE_INSTR = mem_q[rptr_q];
  assign oISSUE_VALID = issue_valid;
  assign oSYNC_WAIT   = sync_wait;
  assign oCOUNT       = count_q;

endmodule

// File: tb/tb_gppcu_instr_queue.sv
// Directed bench for gppcu_instr_queue: fill/drain, SYNC handling, steady push/pop, flush and
// asynchronous reset during a SYNC wait.
module tb_gppcu_instr_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic        issue_ready;
  logic        core_idle;
  logic        flush;
  logic [4:0]  count;
  logic        sync_wait;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] head;

  gppcu_instr_queue dut (
    .iACLK        (clk),
    .iARESETn     (rst_n),
    .iINSTR       (instr),
    .iINSTR_VALID (instr_valid),
    .oINSTR_READY (instr_ready),
    .oISSUE_INSTR (issue_instr),
    .oISSUE_VALID (issue_valid),
    .iISSUE_READY (issue_ready),
    .iCORE_IDLE   (core_idle),
    .iFLUSH       (flush),
    .oCOUNT       (count),
    .oSYNC_WAIT   (sync_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    issue_ready = 1'b0;
    core_idle   = 1'b0;
    flush       = 1'b0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_valid", 32'(issue_valid), 32'd0);
    check("rst_sync", 32'(sync_wait), 32'd0);
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    // Fill to 16 with no issue; first word must not issue in its push cycle.
    for (int i = 1; i <= 16; i++) begin
      instr       = 32'(i);
      instr_valid = 1'b1;
      if (i == 1) check("empty_no_issue", 32'(issue_valid), 32'd0);
      step();
      if (i == 1) begin
        check("latency_valid", 32'(issue_valid), 32'd1);
        check("latency_instr", issue_instr, 32'd1);
      end
    end
    check("full_count", 32'(count), 32'd16);
    check("full_ready", 32'(instr_ready), 32'd0);
    instr = 32'h11;
    step();
    check("push17_blocked", 32'(count), 32'd16);
    check("stall_stable", issue_instr, 32'd1);

    // Drain; the 0x99 offered while full and popping must be refused.
    issue_ready = 1'b1;
    instr       = 32'h99;
    for (int i = 1; i <= 16; i++) begin
      check("drain_valid", 32'(issue_valid), 32'd1);
      check("drain_order", issue_instr, 32'(i));
      step();
      if (i == 1) begin
        check("full_pop_push_blocked", 32'(count), 32'd15);
        instr_valid = 1'b0;
      end
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid_low", 32'(issue_valid), 32'd0);

    // SYNC sequence.
    issue_ready = 1'b0;
    instr_valid = 1'b1;
    instr = 32'h12345678; step();
    instr = 32'hF0000000; step();
    instr = 32'h0000ABCD; step();
    instr_valid = 1'b0;
    check("sync_pre_instr", issue_instr, 32'h12345678);
    check("sync_pre_valid", 32'(issue_valid), 32'd1);
    issue_ready = 1'b1;
    step();
    check("sync_head_blocked", 32'(issue_valid), 32'd0);
    step();
    check("sync_wait_hi", 32'(sync_wait), 32'd1);
    check("sync_wait_valid", 32'(issue_valid), 32'd0);
    step();
    check("sync_wait_hold", 32'(sync_wait), 32'd1);
    check("sync_wait_count", 32'(count), 32'd2);
    core_idle = 1'b1;
    step();
    core_idle = 1'b0;
    check("sync_release", 32'(sync_wait), 32'd0);
    check("sync_next_valid", 32'(issue_valid), 32'd1);
    check("sync_next_instr", issue_instr, 32'h0000ABCD);
    step();
    check("sync_done_count", 32'(count), 32'd0);

    // Steady push/pop at occupancy 5, checked against a reference queue.
    issue_ready = 1'b0;
    instr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      instr = 32'h100 + 32'(k);
      exp_q.push_back(instr);
      step();
    end
    check("pp_start_count", 32'(count), 32'd5);
    issue_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      instr = 32'h200 + 32'(k);
      exp_q.push_back(instr);
      head = exp_q.pop_front();
      check("pp_valid", 32'(issue_valid), 32'd1);
      check("pp_order", issue_instr, head);
      step();
      check("pp_count", 32'(count), 32'd5);
    end
    instr_valid = 1'b0;
    while (exp_q.size() != 0) begin
      head = exp_q.pop_front();
      check("pp_tail_order", issue_instr, head);
      step();
    end
    check("pp_end_count", 32'(count), 32'd0);

    // Flush at occupancy 7 with a concurrent push.
    issue_ready = 1'b0;
    instr_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      instr = 32'h300 + 32'(k);
      step();
    end
    check("flush_pre_count", 32'(count), 32'd7);
    instr = 32'h3FF;
    flush = 1'b1;
    step();
    flush       = 1'b0;
    instr_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(issue_valid), 32'd0);
    check("flush_ready", 32'(instr_ready), 32'd1);

    // Async reset while waiting on a SYNC.
    instr_valid = 1'b1;
    instr = 32'hF0000001; step();
    instr = 32'h00000042; step();
    instr_valid = 1'b0;
    step();
    check("rst2_pre_sync", 32'(sync_wait), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_sync", 32'(sync_wait), 32'd0);
    check("rst2_count", 32'(count), 32'd0);
    check("rst2_ready", 32'(instr_ready), 32'd1);
    step();
    #2 rst_n = 1'b1;
    instr_valid = 1'b1;
    instr = 32'h0000BEEF;
    step();
    instr_valid = 1'b0;
    check("resume_count", 32'(count), 32'd1);
    check("resume_instr", issue_instr, 32'h0000BEEF);
    check("resume_valid", 32'(issue_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
